apb_coeff_bank: RTL and testbench

- Parametrised APB3 slave that holds filter coefficients for N_CH filter channels.
- Each channel has N_COEFF coefficients, double-buffered as a shadow bank (written over APB) and an active bank (drives the datapath).
- Software commits a channel; the shadow bank is copied to the active bank atomically at the datapath's next swap-safe cycle, so taps never change mid-sample.
- Wait states and PSLVERR are supported; the block replaces single-bank coefficient RAMs in the DFE filter array.

---
 rtl/apb_coeff_bank.sv | 172 +++++++++++++++++
 tb/tb_apb_coeff_bank.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_coeff_bank.sv
// APB3 double-buffered coefficient bank.
// Software writes a shadow bank per channel and then commits it. The shadow bank
// is copied to the active bank in one edge when the datapath raises SWAP_EN for
// that channel, so filter taps never change part-way through a sample.
module apb_coeff_bank #(
    parameter int ADDR_WIDTH  = 7,
    parameter int PDATA_WIDTH = 32,
    parameter int COEFF_WIDTH = 20,
    parameter int N_CH        = 4,
    parameter int N_COEFF     = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                PSEL,
    input  logic                                PENABLE,
    input  logic                                PWRITE,
    input  logic [ADDR_WIDTH-1:0]               PADDR,
    input  logic [PDATA_WIDTH-1:0]              PWDATA,
    output logic                                PREADY,
    output logic [PDATA_WIDTH-1:0]              PRDATA,
    output logic                                PSLVERR,
    input  logic [N_CH-1:0]                     SWAP_EN,
    output logic [N_CH*N_COEFF*COEFF_WIDTH-1:0] COEFF_OUT,
    output logic [N_CH-1:0]                     COEFF_VLD,
    output logic [N_CH-1:0]                     PENDING
);
    localparam int N_TOT = N_CH * N_COEFF;
    localparam int WC_W  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    localparam logic [ADDR_WIDTH-1:0] A_COMMIT = ADDR_WIDTH'((2 ** ADDR_WIDTH) - 4);
    localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'((2 ** ADDR_WIDTH) - 3);
    localparam logic [ADDR_WIDTH-1:0] A_PARAM  = ADDR_WIDTH'((2 ** ADDR_WIDTH) - 2);
    localparam logic [ADDR_WIDTH-1:0] A_NTOT   = ADDR_WIDTH'(N_TOT);

    logic signed [COEFF_WIDTH-1:0] shadow [N_TOT];
    logic signed [COEFF_WIDTH-1:0] active [N_TOT];
    logic signed [COEFF_WIDTH-1:0] rd_coef;

    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] pending_nxt;
    logic [N_CH-1:0] coeff_vld;
    logic [N_CH-1:0] swap;
    logic [WC_W-1:0] wc;

    logic access;
    logic is_coef;
    logic is_commit;
    logic is_status;
    logic is_param;
    logic hit_pending;
    logic err;
    logic wr_ok;
    logic rd_ok;
    logic unused_bits;

    // Only the low COEFF_WIDTH / 2*N_CH write-data bits carry meaning.
    assign unused_bits = ^PWDATA;

    assign access  = PSEL & PENABLE;
    assign PREADY  = access & (wc == WC_W'(WAIT_STATES));
    assign PSLVERR = PREADY & err;
    assign wr_ok   = PREADY & PWRITE & ~err;
    assign rd_ok   = PREADY & ~PWRITE & ~err;
    assign swap    = pending & SWAP_EN;

    assign is_coef   = (PADDR < A_NTOT);
    assign is_commit = (PADDR == A_COMMIT);
    assign is_status = (PADDR == A_STATUS);
    assign is_param  = (PADDR == A_PARAM);

    // Address decode: pick the addressed shadow word and its channel's pending bit.
    always_comb begin
        rd_coef     = '0;
        hit_pending = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            for (int i = 0; i < N_COEFF; i++) begin
                if (PADDR == ADDR_WIDTH'(c * N_COEFF + i)) begin
                    rd_coef     = shadow[c * N_COEFF + i];
                    hit_pending = pending[c];
                end
            end
        end
    end

    // Error rules: unmapped/reserved, wrong direction, or writing a queued channel.
    always_comb begin
        if (PWRITE) begin
            err = is_coef ? hit_pending : ~is_commit;
        end else begin
            err = ~(is_coef | is_status | is_param);
        end
    end

    // Read data is only driven on an error-free read completion.
    always_comb begin
        PRDATA = '0;
        if (rd_ok) begin
            if (is_coef) begin
                PRDATA = PDATA_WIDTH'(rd_coef);
            end else if (is_status) begin
                PRDATA = PDATA_WIDTH'(pending);
            end else begin
                PRDATA = PDATA_WIDTH'({8'(N_CH), 16'(N_COEFF)});
            end
        end
    end

    // Swap retires a pending bit; a commit on the same edge re-queues it, abort wins over set.
    always_comb begin
        pending_nxt = pending & ~swap;
        if (wr_ok && is_commit) begin
            pending_nxt = (pending_nxt | PWDATA[N_CH-1:0]) & ~PWDATA[2*N_CH-1:N_CH];
        end
    end

    // Wait-state counter: counts stalled access cycles, restarts every transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wc <= '0;
        end else if (access && !PREADY) begin
            wc <= wc + WC_W'(1);
        end else begin
            wc <= '0;
        end
    end

    // Shadow bank: written by software on error-free write completions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_TOT; k++) shadow[k] <= '0;
        end else if (wr_ok && is_coef) begin
            for (int k = 0; k < N_TOT; k++) begin
                if (PADDR == ADDR_WIDTH'(k)) shadow[k] <= PWDATA[COEFF_WIDTH-1:0];
            end
        end
    end

    // Active bank: whole-channel copy from shadow on a swap, flagged for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_TOT; k++) active[k] <= '0;
            coeff_vld <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (swap[c]) begin
                    for (int i = 0; i < N_COEFF; i++) begin
                        active[c * N_COEFF + i] <= shadow[c * N_COEFF + i];
                    end
                end
            end
            coeff_vld <= swap;
        end
    end

    // Commit-pending mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    for (genvar k = 0; k < N_TOT; k++) begin : g_out
        assign COEFF_OUT[k*COEFF_WIDTH +: COEFF_WIDTH] = active[k];
    end

    assign COEFF_VLD = coeff_vld;
    assign PENDING   = pending;

endmodule

// File: tb/tb_apb_coeff_bank.sv
// Bench for apb_coeff_bank: directed scenarios plus randomized APB traffic
// against a behavioural model of the shadow/active banks and commit mask.
module tb_apb_coeff_bank;
    localparam int AW = 7;
    localparam int DW = 32;
    localparam int CW = 20;
    localparam int NC = 4;
    localparam int NK = 16;
    localparam int NT = NC * NK;
    localparam int A_COMMIT = 124;
    localparam int A_STATUS = 125;
    localparam int A_PARAM  = 126;
    localparam int A_RSVD   = 127;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           psel = 0, penable = 0, pwrite = 0;
    logic [AW-1:0]  paddr = '0;
    logic [DW-1:0]  pwdata = '0;
    logic           pready, pslverr;
    logic [DW-1:0]  prdata;
    logic [NC-1:0]  swap_en = '0;
    logic [NC*NK*CW-1:0] coeff_out;
    logic [NC-1:0]  coeff_vld, pending;

    logic           w_psel = 0, w_penable = 0, w_pwrite = 0;
    logic [AW-1:0]  w_paddr = '0;
    logic [DW-1:0]  w_pwdata = '0;
    logic           w_pready, w_pslverr;
    logic [DW-1:0]  w_prdata;
    logic [NC*NK*CW-1:0] w_coeff_out;
    logic [NC-1:0]  w_coeff_vld, w_pending;

    apb_coeff_bank #(.ADDR_WIDTH(AW), .PDATA_WIDTH(DW), .COEFF_WIDTH(CW),
                     .N_CH(NC), .N_COEFF(NK), .WAIT_STATES(0)) dut (
        .clk(clk), .rst_n(rst_n), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready), .PRDATA(prdata),
        .PSLVERR(pslverr), .SWAP_EN(swap_en), .COEFF_OUT(coeff_out),
        .COEFF_VLD(coeff_vld), .PENDING(pending));

    apb_coeff_bank #(.ADDR_WIDTH(AW), .PDATA_WIDTH(DW), .COEFF_WIDTH(CW),
                     .N_CH(NC), .N_COEFF(NK), .WAIT_STATES(3)) dut_ws (
        .clk(clk), .rst_n(rst_n), .PSEL(w_psel), .PENABLE(w_penable), .PWRITE(w_pwrite),
        .PADDR(w_paddr), .PWDATA(w_pwdata), .PREADY(w_pready), .PRDATA(w_prdata),
        .PSLVERR(w_pslverr), .SWAP_EN(4'b0000), .COEFF_OUT(w_coeff_out),
        .COEFF_VLD(w_coeff_vld), .PENDING(w_pending));

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic signed [CW-1:0] m_shadow [NT];
    logic signed [CW-1:0] m_active [NT];
    logic [NC-1:0] m_pend = '0;
    logic [NC-1:0] m_vld = '0;
    logic [NC-1:0] m_old;
    logic          m_e;
    logic [NC*NK*CW-1:0] exp_out;

    function automatic logic m_err(input logic w, input int a);
        if (a < NT) return w && m_pend[a / NK];
        if (a == A_COMMIT) return !w;
        if (a == A_STATUS || a == A_PARAM) return w;
        return 1'b1;
    endfunction

    function automatic logic [DW-1:0] m_rdata(input int a);
        if (a < NT) return DW'(m_shadow[a]);
        if (a == A_STATUS) return DW'(m_pend);
        return DW'((NC << 16) | NK);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NT; k++) begin
                m_shadow[k] = '0;
                m_active[k] = '0;
            end
            m_pend = '0;
            m_vld  = '0;
        end else begin
            m_old = m_pend;
            m_e   = m_err(pwrite, int'(paddr));
            m_vld = '0;
            for (int c = 0; c < NC; c++) begin
                if (m_old[c] && swap_en[c]) begin
                    for (int i = 0; i < NK; i++) m_active[c*NK + i] = m_shadow[c*NK + i];
                    m_pend[c] = 1'b0;
                    m_vld[c]  = 1'b1;
                end
            end
            if (psel && penable && pwrite && !m_e) begin
                if (int'(paddr) < NT) m_shadow[paddr] = pwdata[CW-1:0];
                else m_pend = (m_pend | pwdata[NC-1:0]) & ~pwdata[2*NC-1:NC];
            end
        end
    end

    // Registered outputs compared against the model every cycle.
    always @(negedge clk) begin
        for (int k = 0; k < NT; k++) exp_out[k*CW +: CW] = m_active[k];
        checks++;
        if (coeff_out !== exp_out) begin
            failures++;
            $display("FAIL coeff_out actual_lo=%0h required_lo=%0h", coeff_out[63:0], exp_out[63:0]);
        end
        check("coeff_vld", 64'(coeff_vld), 64'(m_vld));
        check("pending", 64'(pending), 64'(m_pend));
    end

    // ---------------- stimulus ----------------
    task automatic apb(input logic w, input int a, input logic [DW-1:0] d,
                       input logic [NC-1:0] sw_s, input logic [NC-1:0] sw_a,
                       output logic [DW-1:0] rd, output logic err);
        logic exp_err;
        logic [DW-1:0] exp_rd;
        @(posedge clk); #2;
        psel = 1; penable = 0; pwrite = w; paddr = AW'(a); pwdata = d; swap_en = sw_s;
        #1 check("setup_pready", 64'(pready), 64'(0));
        @(posedge clk); #2;
        penable = 1; swap_en = sw_a;
        #1;
        exp_err = m_err(w, a);
        exp_rd  = (w || exp_err) ? '0 : m_rdata(a);
        check("pready", 64'(pready), 64'(1));
        check("pslverr", 64'(pslverr), 64'(exp_err));
        check("prdata", 64'(prdata), 64'(exp_rd));
        rd = prdata;
        err = pslverr;
        @(posedge clk); #2;
        psel = 0; penable = 0; swap_en = '0;
    endtask

    task automatic ws_xfer(input logic w, input int a, input logic [DW-1:0] d,
                           output logic [DW-1:0] rd, output logic err, output int waits);
        waits = 0;
        @(posedge clk); #2;
        w_psel = 1; w_penable = 0; w_pwrite = w; w_paddr = AW'(a); w_pwdata = d;
        #1 check("ws_setup_pready", 64'(w_pready), 64'(0));
        @(posedge clk); #2;
        w_penable = 1;
        #1;
        while (!w_pready && waits < 10) begin
            check("ws_wait_prdata", 64'(w_prdata), 64'(0));
            waits++;
            @(posedge clk); #3;
        end
        if (!w_pready) check("ws_timeout", 64'(0), 64'(1));
        rd = w_prdata;
        err = w_pslverr;
        @(posedge clk); #2;
        w_psel = 0; w_penable = 0;
    endtask

    logic [DW-1:0] rd;
    logic err;
    int waits;
    int sel, a, nidle;
    logic w;
    logic [DW-1:0] d;
    logic [NC-1:0] sw_s, sw_a;

    initial begin
        repeat (3) @(posedge clk);
        #2 rst_n = 1;
        #1;
        check("reset_coeff_out", 64'(|coeff_out), 64'(0));
        check("reset_pending", 64'(pending), 64'(0));

        apb(0, A_STATUS, 0, 0, 0, rd, err);
        check("status_reset", 64'(rd), 64'h0);
        check("status_err", 64'(err), 64'(0));
        apb(0, A_PARAM, 0, 0, 0, rd, err);
        check("param", 64'(rd), 64'h0004_0010);

        apb(1, 17, 32'hFFFF_8000, 0, 0, rd, err);
        apb(0, 17, 0, 0, 0, rd, err);
        check("readback_17", 64'(rd), 64'hFFFF_8000);
        check("active_unchanged", 64'(coeff_out[17*CW +: CW]), 64'(0));

        apb(1, A_COMMIT, 32'h2, 0, 0, rd, err);
        repeat (5) @(posedge clk);
        #3 check("pending_held", 64'(pending), 64'h2);
        @(posedge clk); #2 swap_en = 4'b0010;
        @(posedge clk); #2 swap_en = 4'b0000;
        #1;
        check("swap_vld", 64'(coeff_vld), 64'h2);
        check("swap_pending", 64'(pending), 64'h0);
        check("swap_ch1_i1", 64'(coeff_out[17*CW +: CW]), 64'hF8000);
        check("ch0_i1_untouched", 64'(coeff_out[1*CW +: CW]), 64'h0);
        @(posedge clk); #3 check("vld_one_cycle", 64'(coeff_vld), 64'h0);

        apb(1, A_COMMIT, 32'h2, 0, 0, rd, err);
        apb(1, 18, 32'h5, 0, 0, rd, err);
        check("write_pending_err", 64'(err), 64'(1));
        apb(0, 18, 0, 0, 0, rd, err);
        check("shadow_18_unchanged", 64'(rd), 64'h0);
        apb(1, A_COMMIT, 32'h20, 0, 0, rd, err);
        #1 check("abort_pending", 64'(pending), 64'h0);
        @(posedge clk); #2 swap_en = 4'b0010;
        @(posedge clk); #2 swap_en = 4'b0000;
        #1 check("abort_no_swap", 64'(coeff_vld), 64'h0);

        apb(1, 100, 32'h1, 0, 0, rd, err);
        check("gap_err", 64'(err), 64'(1));
        apb(1, A_STATUS, 32'h1, 0, 0, rd, err);
        check("status_write_err", 64'(err), 64'(1));
        apb(0, A_COMMIT, 0, 0, 0, rd, err);
        check("commit_read_err", 64'(err), 64'(1));
        apb(0, A_RSVD, 0, 0, 0, rd, err);
        check("rsvd_err", 64'(err), 64'(1));

        apb(1, 3, 32'h0000_0ABC, 0, 0, rd, err);
        apb(1, A_COMMIT, 32'h1, 0, 0, rd, err);
        apb(1, A_COMMIT, 32'h1, 4'b0000, 4'b0001, rd, err);
        #1;
        check("same_edge_pending", 64'(pending), 64'h1);
        check("same_edge_vld", 64'(coeff_vld), 64'h1);
        check("same_edge_active", 64'(coeff_out[3*CW +: CW]), 64'hABC);
        apb(1, A_COMMIT, 32'h10, 0, 0, rd, err);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 9);
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            case (sel)
                6: begin a = A_COMMIT; w = ($urandom_range(0, 4) != 0); d = DW'($urandom_range(0, 255)); end
                7: a = A_STATUS;
                8: a = A_PARAM;
                9: a = $urandom_range(NT, A_RSVD);
                default: a = $urandom_range(0, NT - 1);
            endcase
            sw_s = ($urandom_range(0, 3) == 0) ? NC'($urandom) : '0;
            sw_a = ($urandom_range(0, 3) == 0) ? NC'($urandom) : '0;
            apb(w, a, d, sw_s, sw_a, rd, err);
            nidle = $urandom_range(0, 2);
            for (int j = 0; j < nidle; j++) begin
                swap_en = ($urandom_range(0, 2) == 0) ? NC'($urandom) : '0;
                @(posedge clk); #2;
            end
            swap_en = '0;
        end

        // Wait-state instance
        ws_xfer(1, 0, 32'h0001_2345, rd, err, waits);
        check("ws_write_waits", 64'(waits), 64'(3));
        check("ws_write_err", 64'(err), 64'(0));
        ws_xfer(0, 0, 0, rd, err, waits);
        check("ws_read_waits", 64'(waits), 64'(3));
        check("ws_readback", 64'(rd), 64'h0001_2345);
        @(posedge clk); #2;
        w_psel = 1; w_pwrite = 1; w_paddr = AW'(1); w_pwdata = 32'h777;
        @(posedge clk); #2 w_penable = 1;
        repeat (2) @(posedge clk);
        #2 w_psel = 0; w_penable = 0;
        ws_xfer(0, 1, 0, rd, err, waits);
        check("ws_abandoned_write", 64'(rd), 64'h0);

        // Reset in the middle of a transfer
        apb(1, 5, 32'h0000_0321, 0, 0, rd, err);
        apb(1, A_COMMIT, 32'h1, 0, 0, rd, err);
        @(posedge clk); #2 swap_en = 4'b0001;
        @(posedge clk); #2 swap_en = 4'b0000;
        #1 check("pre_reset_active", 64'(coeff_out[5*CW +: CW]), 64'h321);
        psel = 1; pwrite = 1; paddr = AW'(6); pwdata = 32'h55;
        @(posedge clk); #2 penable = 0; rst_n = 0;
        #1;
        check("midreset_active", 64'(|coeff_out), 64'(0));
        check("midreset_pending", 64'(pending), 64'h0);
        check("midreset_pready", 64'(pready), 64'(0));
        psel = 0;
        @(posedge clk); #2 rst_n = 1;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
